// File: rtl/pcss_pkg.sv
// Shared constants and FSM encoding for the inter-chip PCSS link.
// Both the receive and transmit sides import this package.
package pcss_pkg;

  localparam int CHIPDATA_WIDTH = 16;
  localparam int FLITS          = 4;
  localparam int PKT_W          = CHIPDATA_WIDTH * FLITS;
  localparam int ERRW           = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/pcss_sync2.sv
// Two-flop synchronizer for a single-bit level crossing into clk.
// Used on the receive side; the transmit side reuses it.
module pcss_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pcss_chip_rx.sv
// Inter-chip receiver: four-phase flit handshake with parity check,
// assembles FLITS flits MSB-first into one packet for the core router.
module pcss_chip_rx #(
  parameter int CHIPDATA_WIDTH = pcss_pkg::CHIPDATA_WIDTH,
  parameter int FLITS          = pcss_pkg::FLITS,
  parameter int PKT_W          = CHIPDATA_WIDTH * FLITS,
  parameter int ERRW           = pcss_pkg::ERRW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
  input  logic                      recv_data_valid,
  input  logic                      recv_data_par,
  output logic                      recv_data_ready,
  output logic                      recv_data_err,
  output logic [PKT_W-1:0]          pkt_out,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [ERRW-1:0]           err_cnt
);

  import pcss_pkg::*;

  // Handshakes:
  //  link side  : four-phase. The neighbour raises recv_data_valid with data and
  //               parity stable; we raise recv_data_ready (with recv_data_err for a
  //               parity fault) and hold it until valid drops, then drop ready.
  //  router side: valid/ready. pkt_out transfers on a clk edge where pkt_valid and
  //               pkt_ready are both 1; pkt_out is stable while pkt_valid waits.

  localparam int CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int BUF_W = CHIPDATA_WIDTH * (FLITS - 1);
  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);
  localparam logic [ERRW-1:0]  ERR_MAX   = {ERRW{1'b1}};

  rx_state_t                    state, state_n;
  logic                         valid_s;
  logic                         ready_n, err_n, pkt_valid_n;
  logic [CNT_W-1:0]             flit_cnt, flit_cnt_n;
  logic [BUF_W-1:0]             flit_buf, flit_buf_n;
  logic [PKT_W-1:0]             pkt_out_n;
  logic [ERRW-1:0]              err_cnt_n;
  logic [BUF_W+CHIPDATA_WIDTH-1:0] shifted;
  logic                         par_bad, slot_free;

  pcss_sync2 u_valid_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (recv_data_valid),
    .q    (valid_s)
  );

  assign shifted   = {flit_buf, recv_data_in};
  assign par_bad   = recv_data_par != (^recv_data_in);
  assign slot_free = !pkt_valid || pkt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      recv_data_ready <= 1'b0;
      recv_data_err   <= 1'b0;
      flit_cnt        <= '0;
      flit_buf        <= '0;
      pkt_out         <= '0;
      pkt_valid       <= 1'b0;
      err_cnt         <= '0;
    end else begin
      state           <= state_n;
      recv_data_ready <= ready_n;
      recv_data_err   <= err_n;
      flit_cnt        <= flit_cnt_n;
      flit_buf        <= flit_buf_n;
      pkt_out         <= pkt_out_n;
      pkt_valid       <= pkt_valid_n;
      err_cnt         <= err_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    ready_n     = recv_data_ready;
    err_n       = recv_data_err;
    flit_cnt_n  = flit_cnt;
    flit_buf_n  = flit_buf;
    pkt_out_n   = pkt_out;
    pkt_valid_n = pkt_valid;
    err_cnt_n   = err_cnt;

    if (pkt_valid && pkt_ready) pkt_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (valid_s) begin
          if (par_bad) begin
            state_n = ACK;
            ready_n = 1'b1;
            err_n   = 1'b1;
            if (err_cnt != ERR_MAX) err_cnt_n = err_cnt + ERRW'(1);
          end else if (flit_cnt != LAST_FLIT) begin
            state_n    = ACK;
            ready_n    = 1'b1;
            err_n      = 1'b0;
            flit_buf_n = shifted[BUF_W-1:0];
            flit_cnt_n = flit_cnt + CNT_W'(1);
          end else if (slot_free) begin
            // Last flit only acknowledged once the router slot can take the packet.
            state_n     = ACK;
            ready_n     = 1'b1;
            err_n       = 1'b0;
            pkt_out_n   = shifted;
            pkt_valid_n = 1'b1;
            flit_cnt_n  = '0;
          end
        end
      end
      ACK: begin
        if (!valid_s) begin
          state_n = IDLE;
          ready_n = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b0;
        err_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pcss_chip_rx.sv
// Self-checking bench for pcss_chip_rx: directed link scenarios plus randomized
// flits/back-pressure scored against a queue-based packet model.
module tb_pcss_chip_rx;

  localparam int W   = 16;
  localparam int N   = 4;
  localparam int PW  = 64;
  localparam int EW  = 8;
  localparam int TMO = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  recv_data_in = '0;
  logic          recv_data_valid = 1'b0;
  logic          recv_data_par = 1'b0;
  logic          recv_data_ready;
  logic          recv_data_err;
  logic [PW-1:0] pkt_out;
  logic          pkt_valid;
  logic          pkt_ready = 1'b1;
  logic [EW-1:0] err_cnt;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [PW-1:0] exp_q[$];
  logic [W-1:0]  m_flits[$];
  int            m_err = 0;
  int            pv_cycles = 0;
  logic [PW-1:0] last_pkt = '0;
  bit            rand_ready_en = 0;

  pcss_chip_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .recv_data_in   (recv_data_in),
    .recv_data_valid(recv_data_valid),
    .recv_data_par  (recv_data_par),
    .recv_data_ready(recv_data_ready),
    .recv_data_err  (recv_data_err),
    .pkt_out        (pkt_out),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .err_cnt        (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a packet is consumed on an edge where pkt_valid && pkt_ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_valid) pv_cycles++;
      if (pkt_valid && pkt_ready) begin
        check("pkt_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("pkt_data", pkt_out, exp_q.pop_front());
        last_pkt = pkt_out;
      end
    end
  end

  initial begin
    while (1) begin
      @(posedge clk); #1;
      if (rand_ready_en) pkt_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: good flits collect in arrival order; every N of them form
  // one packet, first flit in the most significant position.
  task automatic model_flit(input logic [W-1:0] d, input bit bad);
    if (bad) begin
      if (m_err < (1 << EW) - 1) m_err++;
    end else begin
      m_flits.push_back(d);
      if (m_flits.size() == N) begin
        exp_q.push_back({m_flits[0], m_flits[1], m_flits[2], m_flits[3]});
        m_flits.delete();
      end
    end
  endtask

  task automatic raise_flit(input logic [W-1:0] d, input bit bad);
    model_flit(d, bad);
    @(posedge clk); #1;
    recv_data_in    = d;
    recv_data_par   = bad ? ~(^d) : (^d);
    recv_data_valid = 1'b1;
  endtask

  task automatic wait_ready(input logic lvl, output int edges);
    edges = 0;
    while (recv_data_ready !== lvl && edges < TMO) begin
      @(posedge clk); #1;
      edges++;
    end
    check(lvl ? "ready_rise_timeout" : "ready_fall_timeout", recv_data_ready, lvl);
  endtask

  task automatic drop_flit();
    int edges;
    recv_data_valid = 1'b0;
    wait_ready(1'b0, edges);
    check("err_after_release", recv_data_err, 1'b0);
    recv_data_in  = W'($urandom);
    recv_data_par = 1'($urandom);
  endtask

  task automatic send_flit(input logic [W-1:0] d, input bit bad, output int lat);
    raise_flit(d, bad);
    wait_ready(1'b1, lat);
    check("err_flag", recv_data_err, bad);
    drop_flit();
  endtask

  task automatic do_reset();
    check("pending_pkts_before_reset", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    recv_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", recv_data_ready, 1'b0);
    check("rst_err", recv_data_err, 1'b0);
    check("rst_pkt_valid", pkt_valid, 1'b0);
    check("rst_pkt_out", pkt_out, 64'd0);
    check("rst_err_cnt", err_cnt, 8'd0);
    m_flits.delete();
    m_err = 0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int lat;
    int pv0;
    logic [W-1:0] a_flits[4];
    logic [W-1:0] b_flits[4];

    do_reset();

    // Basic packet, latency and single-cycle pkt_valid
    pkt_ready = 1'b1;
    pv0 = pv_cycles;
    send_flit(16'h0123, 0, lat);
    check("valid_to_ready_edges", 64'(lat), 64'd3);
    send_flit(16'h4567, 0, lat);
    send_flit(16'h89AB, 0, lat);
    send_flit(16'hCDEF, 0, lat);
    repeat (3) @(posedge clk);
    #1;
    check("basic_pkt", last_pkt, 64'h0123_4567_89AB_CDEF);
    check("basic_pulse_cycles", 64'(pv_cycles - pv0), 64'd1);
    check("basic_err_cnt", err_cnt, 8'd0);

    // Bad parity on flit 1, then resent
    do_reset();
    send_flit(16'h0123, 0, lat);
    send_flit(16'h4567, 1, lat);
    send_flit(16'h4567, 0, lat);
    send_flit(16'h89AB, 0, lat);
    send_flit(16'hCDEF, 0, lat);
    repeat (3) @(posedge clk);
    #1;
    check("parity_err_cnt", err_cnt, 8'd1);
    check("parity_pkt", last_pkt, 64'h0123_4567_89AB_CDEF);

    // Back-pressure: two packets against a blocked router
    do_reset();
    a_flits = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    b_flits = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
    pkt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_flit(a_flits[i], 0, lat);
    for (int i = 0; i < 3; i++) send_flit(b_flits[i], 0, lat);
    raise_flit(b_flits[3], 0);
    repeat (10) @(posedge clk);
    #1;
    check("stall_ready_low", recv_data_ready, 1'b0);
    check("stall_pkt_valid", pkt_valid, 1'b1);
    check("stall_pkt_hold", pkt_out, 64'hA001_A002_A003_A004);
    pkt_ready = 1'b1;
    wait_ready(1'b1, lat);
    check("drain_ready_within_3", 64'(lat <= 3), 64'd1);
    check("drain_new_pkt_loaded", pkt_out, 64'hB001_B002_B003_B004);
    drop_flit();
    repeat (3) @(posedge clk);
    #1;
    check("drain_last_pkt", last_pkt, 64'hB001_B002_B003_B004);

    // Reset mid-packet discards the partial flits
    send_flit(16'hAAAA, 0, lat);
    send_flit(16'hBBBB, 0, lat);
    do_reset();
    send_flit(16'h1111, 0, lat);
    send_flit(16'h2222, 0, lat);
    send_flit(16'h3333, 0, lat);
    send_flit(16'h4444, 0, lat);
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_pkt", last_pkt, 64'h1111_2222_3333_4444);

    // Random flits, parity faults, idle gaps and router back-pressure
    rand_ready_en = 1;
    for (int i = 0; i < 48; i++) begin
      send_flit(W'($urandom), ($urandom_range(0, 3) == 0), lat);
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    rand_ready_en = 0;
    repeat (2) @(posedge clk);
    #1;
    pkt_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_err_cnt", err_cnt, 64'(m_err));
    check("rand_all_pkts_seen", 64'(exp_q.size()), 64'd0);

    // Error counter saturation
    do_reset();
    pv0 = pv_cycles;
    for (int i = 0; i < 260; i++) send_flit(W'($urandom), 1, lat);
    repeat (3) @(posedge clk);
    #1;
    check("sat_err_cnt", err_cnt, 8'd255);
    check("sat_model_err_cnt", err_cnt, 64'(m_err));
    check("sat_no_pkt_valid", 64'(pv_cycles - pv0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
